// File: rtl/hazard_pkg.sv
// Shared types, constants and helpers for the RIPTIDE hazard tracker.
package hazard_pkg;

    localparam int unsigned CNT_W    = 16;
    // Stored register index width; indices are zero-extended, so NREGS up to 256 fits.
    localparam int unsigned SB_REG_W = 8;

    typedef struct packed {
        logic                valid;
        logic                wr_en;
        logic [SB_REG_W-1:0] wr_reg;
        logic                cond;
    } sb_entry_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_tracker_if.sv
// Decode-side issue/resolve bus and interlock outputs of the hazard tracker.
interface hazard_tracker_if
    import hazard_pkg::*;
#(
    parameter int unsigned NREGS = 8
);
    localparam int unsigned AW = clog2(NREGS);

    logic             issue_valid;
    logic [AW-1:0]    issue_ra;
    logic [AW-1:0]    issue_rb;
    logic             issue_ra_en;
    logic             issue_rb_en;
    logic [AW-1:0]    issue_wr_reg;
    logic             issue_wr_en;
    logic             issue_cond;
    logic             issue_jmp;
    logic             resolve_taken;
    logic             HALT;
    logic             hazard;
    logic             branch_hazard;
    logic             pipeline_flush;
    logic             decoder_RST;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output issue_valid, issue_ra, issue_rb, issue_ra_en, issue_rb_en,
               issue_wr_reg, issue_wr_en, issue_cond, issue_jmp, resolve_taken, HALT,
        input  hazard, branch_hazard, pipeline_flush, decoder_RST, stall_cycles, flush_count
    );

    modport slave (
        input  issue_valid, issue_ra, issue_rb, issue_ra_en, issue_rb_en,
               issue_wr_reg, issue_wr_en, issue_cond, issue_jmp, resolve_taken, HALT,
        output hazard, branch_hazard, pipeline_flush, decoder_RST, stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight instruction shift register with flush kill and per-stage RAW/cond match vectors.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH     = 5,
    parameter int unsigned RES_STAGE = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                accept_i,
    input  logic                flush_i,
    input  sb_entry_t           issue_i,
    input  logic [SB_REG_W-1:0] ra_i,
    input  logic                ra_en_i,
    input  logic [SB_REG_W-1:0] rb_i,
    input  logic                rb_en_i,
    output logic [DEPTH:1]      raw_match_o,
    output logic [DEPTH:1]      cond_pend_o,
    output logic                res_cond_o
);

    sb_entry_t sb_q [1:DEPTH];
    sb_entry_t sb_d [1:DEPTH];

    // Younger stages are killed before shifting so nothing behind a taken branch survives.
    always_comb begin
        for (int unsigned k = 1; k <= DEPTH; k++) sb_d[k] = '0;
        if (accept_i) sb_d[1] = issue_i;
        for (int unsigned k = 2; k <= DEPTH; k++) begin
            if (!(flush_i && (k - 1 < RES_STAGE))) sb_d[k] = sb_q[k-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 1; k <= DEPTH; k++) sb_q[k] <= '0;
        end else begin
            for (int unsigned k = 1; k <= DEPTH; k++) sb_q[k] <= sb_d[k];
        end
    end

    always_comb begin
        raw_match_o = '0;
        cond_pend_o = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            raw_match_o[k] = sb_q[k].valid && sb_q[k].wr_en &&
                             ((ra_en_i && (sb_q[k].wr_reg == ra_i)) ||
                              (rb_en_i && (sb_q[k].wr_reg == rb_i)));
            cond_pend_o[k] = (k < RES_STAGE) && sb_q[k].valid && sb_q[k].cond;
        end
    end

    assign res_cond_o = sb_q[RES_STAGE].valid && sb_q[RES_STAGE].cond;

endmodule

// File: rtl/hazard_tracker.sv
// RIPTIDE decode interlock/flush controller; HAZARD_PERF_EN enables the stall/flush counters.
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned NREGS      = 8,
    parameter int unsigned DEPTH      = 5,
    parameter int unsigned RES_STAGE  = 4,
    parameter int unsigned FLUSH_HOLD = 2
) (
    input logic              clk,
    input logic              RST,
    hazard_tracker_if.slave  bus_io
);

    localparam int unsigned AW     = clog2(NREGS);
    localparam int unsigned HOLD_W = clog2(FLUSH_HOLD + 1);

    logic                accept;
    logic                data_hazard;
    logic                cond_ahead;
    logic                res_cond;
    logic                flush;
    logic                hold_nz;
    logic                br_hazard;
    logic                any_hazard;
    logic [DEPTH:1]      raw_match;
    logic [DEPTH:1]      cond_pend;
    sb_entry_t           issue_e;
    logic [SB_REG_W-1:0] ra_ext;
    logic [SB_REG_W-1:0] rb_ext;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_d;

    always_comb begin
        issue_e              = '0;
        issue_e.valid        = 1'b1;
        issue_e.wr_en        = bus_io.issue_wr_en;
        issue_e.wr_reg[AW-1:0] = bus_io.issue_wr_reg;
        issue_e.cond         = bus_io.issue_cond;
        ra_ext               = '0;
        ra_ext[AW-1:0]       = bus_io.issue_ra;
        rb_ext               = '0;
        rb_ext[AW-1:0]       = bus_io.issue_rb;
    end

    hazard_scoreboard #(
        .DEPTH     (DEPTH),
        .RES_STAGE (RES_STAGE)
    ) u_sb (
        .clk_i       (clk),
        .rst_i       (RST),
        .accept_i    (accept),
        .flush_i     (flush),
        .issue_i     (issue_e),
        .ra_i        (ra_ext),
        .ra_en_i     (bus_io.issue_ra_en),
        .rb_i        (rb_ext),
        .rb_en_i     (bus_io.issue_rb_en),
        .raw_match_o (raw_match),
        .cond_pend_o (cond_pend),
        .res_cond_o  (res_cond)
    );

    assign data_hazard = |raw_match;
    assign cond_ahead  = |cond_pend;
    assign hold_nz     = (hold_q != '0);
    assign flush       = ~RST & res_cond & bus_io.resolve_taken;
    assign br_hazard   = ~RST & bus_io.issue_valid & bus_io.issue_jmp & cond_ahead;
    assign any_hazard  = ~RST & (bus_io.HALT | flush | hold_nz | data_hazard | br_hazard);
    assign accept      = bus_io.issue_valid & ~any_hazard;

    assign bus_io.hazard         = any_hazard;
    assign bus_io.branch_hazard  = br_hazard;
    assign bus_io.pipeline_flush = flush;
    assign bus_io.decoder_RST    = RST | flush | (accept & bus_io.issue_jmp) | hold_nz;

    always_comb begin
        hold_d = hold_q;
        if (flush || (accept && bus_io.issue_jmp)) hold_d = HOLD_W'(FLUSH_HOLD);
        else if (hold_nz)                          hold_d = hold_q - HOLD_W'(1);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) hold_q <= '0;
        else     hold_q <= hold_d;
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (bus_io.issue_valid && any_hazard && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
        if (flush && (flush_q != '1))                            flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus_io.stall_cycles = stall_q;
    assign bus_io.flush_count  = flush_q;
`else
    assign bus_io.stall_cycles = '0;
    assign bus_io.flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed, table-driven bench for hazard_tracker at default parameters.
module tb_hazard_tracker;
    import hazard_pkg::*;

`ifdef HAZARD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    typedef struct {
        logic       v;
        logic       ra_en;
        logic [2:0] ra;
        logic       rb_en;
        logic [2:0] rb;
        logic       wr_en;
        logic [2:0] wr;
        logic       cond;
        logic       jmp;
        logic       taken;
        logic       halt;
        logic [3:0] exp;   // {hazard, branch_hazard, pipeline_flush, decoder_RST}
    } vec_t;

    logic clk;
    logic RST;
    int   checks;
    int   failures;
    vec_t vecs[$];

    hazard_tracker_if #(.NREGS(8)) bus ();

    hazard_tracker #(
        .NREGS      (8),
        .DEPTH      (5),
        .RES_STAGE  (4),
        .FLUSH_HOLD (2)
    ) dut (
        .clk    (clk),
        .RST    (RST),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int v, input int ra_en, input int ra, input int rb_en,
                                input int rb, input int wr_en, input int wr, input int cond,
                                input int jmp, input int taken, input int halt, input int exp);
        vec_t r;
        r.v     = (v != 0);
        r.ra_en = (ra_en != 0);
        r.ra    = 3'(ra);
        r.rb_en = (rb_en != 0);
        r.rb    = 3'(rb);
        r.wr_en = (wr_en != 0);
        r.wr    = 3'(wr);
        r.cond  = (cond != 0);
        r.jmp   = (jmp != 0);
        r.taken = (taken != 0);
        r.halt  = (halt != 0);
        r.exp   = 4'(exp);
        return r;
    endfunction

    task automatic apply(input vec_t r);
        bus.issue_valid   = r.v;
        bus.issue_ra_en   = r.ra_en;
        bus.issue_ra      = r.ra;
        bus.issue_rb_en   = r.rb_en;
        bus.issue_rb      = r.rb;
        bus.issue_wr_en   = r.wr_en;
        bus.issue_wr_reg  = r.wr;
        bus.issue_cond    = r.cond;
        bus.issue_jmp     = r.jmp;
        bus.resolve_taken = r.taken;
        bus.HALT          = r.halt;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        RST = 1'b1;
        repeat (2) @(negedge clk);
        RST = 1'b0;
    endtask

    logic [3:0] act4;
    int         cnt;
    bit         done;

    initial begin
        checks   = 0;
        failures = 0;
        RST      = 1'b1;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        @(negedge clk);
        #2;
        act4 = {bus.hazard, bus.branch_hazard, bus.pipeline_flush, bus.decoder_RST};
        check("reset_outputs", 32'(act4), 32'h1);
        check("reset_counters", {bus.stall_cycles, bus.flush_count}, 32'h0);

        // c0..c36: RAW stall, unrelated read, taken flush, not-taken branch, jump behind cond, HALT
        vecs.push_back(mk(1, 0,0, 0,0, 1,3, 0,0,0,0, 4'b0000));
        repeat (5) vecs.push_back(mk(1, 1,3, 0,0, 0,0, 0,0,0,0, 4'b1000));
        vecs.push_back(mk(1, 1,3, 0,0, 0,0, 0,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 0,0, 0,0, 1,3, 0,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 1,4, 1,5, 0,0, 0,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 0,0, 0,0, 0,0, 1,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 0,0, 0,0, 1,5, 0,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 0,0, 0,0, 1,6, 0,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 0,0, 0,0, 1,7, 0,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 0,0, 0,0, 1,1, 0,0,1,0, 4'b1011));
        vecs.push_back(mk(1, 0,0, 0,0, 1,1, 0,0,0,0, 4'b1001));
        vecs.push_back(mk(1, 0,0, 0,0, 1,1, 0,0,0,0, 4'b1001));
        vecs.push_back(mk(1, 1,5, 1,6, 0,0, 0,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 0,0, 0,0, 0,0, 1,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 0,0, 0,0, 1,5, 0,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 0,0, 0,0, 1,6, 0,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 0,0, 0,0, 1,7, 0,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 1,5, 0,0, 0,0, 0,0,0,0, 4'b1000));
        vecs.push_back(mk(1, 1,5, 0,0, 0,0, 0,0,1,0, 4'b1000));
        vecs.push_back(mk(1, 1,5, 0,0, 0,0, 0,0,0,0, 4'b1000));
        vecs.push_back(mk(1, 1,5, 0,0, 0,0, 0,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 0,0, 0,0, 0,0, 1,0,0,0, 4'b0000));
        repeat (3) vecs.push_back(mk(1, 0,0, 0,0, 0,0, 0,1,0,0, 4'b1100));
        vecs.push_back(mk(1, 0,0, 0,0, 0,0, 0,1,0,0, 4'b0001));
        vecs.push_back(mk(0, 0,0, 0,0, 0,0, 0,0,0,0, 4'b1001));
        vecs.push_back(mk(0, 0,0, 0,0, 0,0, 0,0,0,0, 4'b1001));
        vecs.push_back(mk(0, 0,0, 0,0, 0,0, 0,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 0,0, 0,0, 0,0, 0,0,0,1, 4'b1000));
        vecs.push_back(mk(1, 1,2, 0,0, 0,0, 0,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 1,2, 0,0, 1,2, 0,0,0,0, 4'b0000));
        vecs.push_back(mk(1, 1,2, 0,0, 0,0, 0,0,0,0, 4'b1000));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #2;
            act4 = {bus.hazard, bus.branch_hazard, bus.pipeline_flush, bus.decoder_RST};
            check($sformatf("vec%0d", i), 32'(act4), 32'(vecs[i].exp));
        end
        @(negedge clk);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        check("table_stall_cycles", 32'(bus.stall_cycles), 32'(PERF * 16));
        check("table_flush_count", 32'(bus.flush_count), 32'(PERF));

        // RAW release timing from a clean scoreboard
        do_reset();
        @(negedge clk);
        apply(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0));
        #2;
        check("raw_writer_accept", 32'(bus.hazard), 32'h0);
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            apply(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            #2;
            if (bus.hazard) cnt++;
            else            done = 1'b1;
        end
        check("raw_release_seen", 32'(done), 32'h1);
        check("raw_stall_len", 32'(cnt), 32'd5);
        @(negedge clk);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        check("raw_stall_cycles", 32'(bus.stall_cycles), 32'(PERF * 5));

        // Asynchronous reset pulsed between edges in the middle of a RAW stall
        do_reset();
        @(negedge clk);
        apply(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0));
        repeat (2) begin
            @(negedge clk);
            apply(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        #2;
        check("mid_stall_hazard", 32'(bus.hazard), 32'h1);
        check("mid_stall_count", 32'(bus.stall_cycles), 32'(PERF * 2));
        RST = 1'b1;
        #1;
        act4 = {bus.hazard, bus.branch_hazard, bus.pipeline_flush, bus.decoder_RST};
        check("async_rst_outputs", 32'(act4), 32'h1);
        check("async_rst_counters", {bus.stall_cycles, bus.flush_count}, 32'h0);
        RST = 1'b0;
        #1;
        act4 = {bus.hazard, bus.branch_hazard, bus.pipeline_flush, bus.decoder_RST};
        check("post_rst_sb_empty", 32'(act4), 32'h0);
        @(negedge clk);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        check("post_rst_stall_count", 32'(bus.stall_cycles), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
